// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM receive path.
// State encoding and default widths used by the demux and its pair counter.
package tdm_pkg;

  typedef enum logic {
    WAIT0 = 1'b0,
    WAIT1 = 1'b1
  } tdm_state_e;

  localparam int unsigned N_DEFAULT  = 2;
  localparam int unsigned CW_DEFAULT = 8;

endpackage

// File: rtl/pair_counter.sv
// Wrapping count of completed I0/I1 pairs; rolls over silently at 2^CW.
module pair_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tdm_demux_2ch.sv
// Reassembles a select-tagged word stream into registered I0/I1 pairs,
// flagging out-of-order words and counting completed pairs.
module tdm_demux_2ch
  import tdm_pkg::*;
#(
  parameter int unsigned n  = N_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [n:0]    in_data,
  input  logic          in_sel,
  output logic [n:0]    out0,
  output logic [n:0]    out1,
  output logic          out_valid,
  output logic          seq_err,
  output logic [CW-1:0] pair_cnt,
  output logic          busy
);

  tdm_state_e state_q, state_d;
  logic [n:0] hold_q, hold_d;
  logic [n:0] out0_q, out0_d;
  logic [n:0] out1_q, out1_d;
  logic       out_valid_q, out_valid_d;
  logic       seq_err_q, seq_err_d;
  logic       pair_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT0;
      hold_q      <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    pair_done   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        WAIT0: begin
          if (!in_sel) begin
            hold_d  = in_data;
            state_d = WAIT1;
          end else begin
            // Stray I1 with no I0 held: drop it.
            seq_err_d = 1'b1;
          end
        end
        WAIT1: begin
          if (in_sel) begin
            out0_d      = hold_q;
            out1_d      = in_data;
            out_valid_d = 1'b1;
            pair_done   = 1'b1;
            state_d     = WAIT0;
          end else begin
            // Repeated I0: newest word replaces the held one.
            hold_d    = in_data;
            seq_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  pair_counter #(
    .CW(CW)
  ) u_pair_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (pair_done),
    .count(pair_cnt)
  );

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;
  assign seq_err   = seq_err_q;
  assign busy      = (state_q == WAIT1);

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Bench for tdm_demux_2ch: vector table through a scoreboard queue, plus
// async-reset and counter-wrap sequences on a CW=2 twin instance.
module tb_tdm_demux_2ch;

  typedef struct {
    logic       v;
    logic       sel;
    logic [2:0] d;
    logic       ev;
    logic       ee;
    logic [2:0] e0;
    logic [2:0] e1;
    logic       eb;
    logic [7:0] ec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_sel = 1'b0;

  logic [2:0] out0, out1, s_out0, s_out1;
  logic       out_valid, seq_err, busy, s_out_valid, s_seq_err, s_busy;
  logic [7:0] pair_cnt;
  logic [1:0] s_pair_cnt;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[22];

  always #5 clk = ~clk;

  tdm_demux_2ch #(
    .n (2),
    .CW(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out0     (out0),
    .out1     (out1),
    .out_valid(out_valid),
    .seq_err  (seq_err),
    .pair_cnt (pair_cnt),
    .busy     (busy)
  );

  tdm_demux_2ch #(
    .n (2),
    .CW(2)
  ) dut_small (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out0     (s_out0),
    .out1     (s_out1),
    .out_valid(s_out_valid),
    .seq_err  (s_seq_err),
    .pair_cnt (s_pair_cnt),
    .busy     (s_busy)
  );

  function automatic vec_t mk(logic v, logic sel, logic [2:0] d, logic ev, logic ee,
                              logic [2:0] e0, logic [2:0] e1, logic eb, logic [7:0] ec);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.ev = ev; r.ee = ee;
    r.e0 = e0; r.e1 = e1; r.eb = eb; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input vec_t e);
    chk("out_valid", {7'b0, out_valid}, {7'b0, e.ev});
    chk("seq_err", {7'b0, seq_err}, {7'b0, e.ee});
    chk("out0", {5'b0, out0}, {5'b0, e.e0});
    chk("out1", {5'b0, out1}, {5'b0, e.e1});
    chk("busy", {7'b0, busy}, {7'b0, e.eb});
    chk("pair_cnt", pair_cnt, e.ec);
    chk("pair_cnt_cw2", {6'b0, s_pair_cnt}, {6'b0, e.ec[1:0]});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t r);
    vec_t e;
    in_valid = r.v;
    in_sel   = r.sel;
    in_data  = r.d;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check_all(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             v  sel d       ev ee e0      e1      eb ec
    tbl[0]  = mk(1, 0, 3'b001, 0, 0, 3'b000, 3'b000, 1, 0);
    tbl[1]  = mk(1, 1, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1);
    tbl[2]  = mk(0, 0, 3'b111, 0, 0, 3'b001, 3'b000, 0, 1);
    tbl[3]  = mk(1, 0, 3'b101, 0, 0, 3'b001, 3'b000, 1, 1);
    tbl[4]  = mk(1, 1, 3'b110, 1, 0, 3'b101, 3'b110, 0, 2);
    tbl[5]  = mk(1, 0, 3'b011, 0, 0, 3'b101, 3'b110, 1, 2);
    tbl[6]  = mk(1, 1, 3'b010, 1, 0, 3'b011, 3'b010, 0, 3);
    tbl[7]  = mk(1, 0, 3'b110, 0, 0, 3'b011, 3'b010, 1, 3);
    tbl[8]  = mk(1, 1, 3'b111, 1, 0, 3'b110, 3'b111, 0, 4);
    tbl[9]  = mk(1, 1, 3'b111, 0, 1, 3'b110, 3'b111, 0, 4);
    tbl[10] = mk(0, 1, 3'b000, 0, 0, 3'b110, 3'b111, 0, 4);
    tbl[11] = mk(1, 0, 3'b001, 0, 0, 3'b110, 3'b111, 1, 4);
    tbl[12] = mk(1, 0, 3'b011, 0, 1, 3'b110, 3'b111, 1, 4);
    tbl[13] = mk(1, 1, 3'b100, 1, 0, 3'b011, 3'b100, 0, 5);
    tbl[14] = mk(1, 0, 3'b101, 0, 0, 3'b011, 3'b100, 1, 5);
    for (int i = 15; i < 20; i++) tbl[i] = mk(0, 1, 3'b110, 0, 0, 3'b011, 3'b100, 1, 5);
    tbl[20] = mk(1, 1, 3'b010, 1, 0, 3'b101, 3'b010, 0, 6);
    tbl[21] = mk(1, 0, 3'b111, 0, 0, 3'b101, 3'b010, 1, 6);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) apply(tbl[i]);

    // Async reset mid-pair, away from any clock edge
    #3 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(1, 0, 3'b010, 0, 0, 3'b000, 3'b000, 1, 0));
    apply(mk(1, 1, 3'b001, 1, 0, 3'b010, 3'b001, 0, 1));

    // Counter wrap: CW=2 instance must read 1,2,3,0,1
    #3 rst = 1'b1;
    #1 check_all(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) begin
      logic [2:0] a, b;
      logic [2:0] p0, p1;
      a = 3'(k);
      b = ~3'(k);
      p0 = (k == 1) ? 3'b000 : 3'(k - 1);
      p1 = (k == 1) ? 3'b000 : ~3'(k - 1);
      apply(mk(1, 0, a, 0, 0, p0, p1, 1, 8'(k - 1)));
      apply(mk(1, 1, b, 1, 0, a, b, 0, 8'(k)));
    end
    chk("wrap_final_cw2", {6'b0, s_pair_cnt}, 8'd1);

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
